// File: rtl/ddr_wr_pkg.sv
// Shared types and constants for the DDR write-burst master.
package ddr_wr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_DATA = 3'd2,
    ST_RESP = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam int DEF_DATA_W     = 256;
  localparam int BYTES_PER_BEAT = DEF_DATA_W / 8;

  localparam logic [1:0] BRESP_OKAY = 2'b00;

  function automatic int bytes_per_beat(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/ddr_wr_burst_master.sv
// Pops prefetch-FIFO words and writes one video frame as fixed-length AXI-style bursts.
// Optional underrun counter output stall_cnt is built when DDR_WR_STALL_CNT_EN is defined.
module ddr_wr_burst_master
  import ddr_wr_pkg::*;
#(
  parameter int DATA_W    = 256,
  parameter int ADDR_W    = 28,
  parameter int BURST_LEN = 16,
  parameter int BEATS_W   = 24
) (
  input  logic               rd_clk,
  input  logic               rd_rst,
  input  logic               frame_start,
  input  logic [ADDR_W-1:0]  frame_base,
  input  logic [BEATS_W-1:0] frame_beats,
  input  logic [DATA_W-1:0]  fifo_data,
  input  logic               fifo_vld,
  output logic               fifo_rd_en,
  output logic [ADDR_W-1:0]  awaddr,
  output logic [7:0]         awlen,
  output logic               awvalid,
  input  logic               awready,
  output logic [DATA_W-1:0]  wdata,
  output logic               wlast,
  output logic               wvalid,
  input  logic               wready,
  input  logic               bvalid,
  input  logic [1:0]         bresp,
  output logic               bready,
  output logic               busy,
  output logic               frame_done,
  output logic               wr_err
`ifdef DDR_WR_STALL_CNT_EN
  ,
  output logic [31:0]        stall_cnt
`endif
);

  localparam int LEN_W      = 9;
  localparam int BEAT_BYTES = bytes_per_beat(DATA_W);

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [BEATS_W-1:0]   remain_q, remain_d;
  logic [LEN_W-1:0]     beat_q, beat_d;
  logic                 wr_err_q, wr_err_d;

  logic [LEN_W-1:0]     len_q;
  logic                 start_acc;
  logic                 beat_xfer;
  logic                 last_beat;
  logic                 resp_acc;

  // Current burst length is derived from the beats still owed for the frame.
  always_comb begin
    if (remain_q >= BEATS_W'(BURST_LEN)) len_q = LEN_W'(BURST_LEN);
    else                                 len_q = LEN_W'(remain_q);
  end

  assign start_acc = (state_q == ST_IDLE) && frame_start;
  assign beat_xfer = (state_q == ST_DATA) && fifo_vld && wready;
  assign last_beat = (beat_q == len_q - LEN_W'(1));
  assign resp_acc  = (state_q == ST_RESP) && bvalid;

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (frame_start) state_d = (frame_beats == '0) ? ST_DONE : ST_ADDR;
      ST_ADDR: if (awready) state_d = ST_DATA;
      ST_DATA: if (beat_xfer && last_beat) state_d = ST_RESP;
      ST_RESP: if (bvalid) state_d = (remain_q == BEATS_W'(len_q)) ? ST_DONE : ST_ADDR;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    awvalid    = (state_q == ST_ADDR);
    awaddr     = (state_q == ST_ADDR) ? addr_q : '0;
    awlen      = (state_q == ST_ADDR) ? 8'(len_q - LEN_W'(1)) : 8'd0;
    wvalid     = (state_q == ST_DATA) && fifo_vld;
    wlast      = (state_q == ST_DATA) && fifo_vld && last_beat;
    fifo_rd_en = (state_q == ST_DATA) && wready;
    wdata      = fifo_data;
    bready     = (state_q == ST_RESP);
    frame_done = (state_q == ST_DONE);
    busy       = (state_q == ST_ADDR) || (state_q == ST_DATA) || (state_q == ST_RESP);
    wr_err     = wr_err_q;
  end

  // Address and remaining-beat bookkeeping advance only once the burst's B arrives.
  always_comb begin
    addr_d   = addr_q;
    remain_d = remain_q;
    beat_d   = beat_q;
    wr_err_d = wr_err_q;
    if (start_acc) begin
      addr_d   = frame_base;
      remain_d = frame_beats;
      beat_d   = '0;
      wr_err_d = 1'b0;
    end
    if (beat_xfer) begin
      beat_d = last_beat ? '0 : beat_q + LEN_W'(1);
    end
    if (resp_acc) begin
      addr_d   = addr_q + ADDR_W'(32'(len_q) * BEAT_BYTES);
      remain_d = remain_q - BEATS_W'(len_q);
      if (bresp != BRESP_OKAY) wr_err_d = 1'b1;
    end
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      addr_q   <= '0;
      remain_q <= '0;
      beat_q   <= '0;
      wr_err_q <= 1'b0;
    end else begin
      addr_q   <= addr_d;
      remain_q <= remain_d;
      beat_q   <= beat_d;
      wr_err_q <= wr_err_d;
    end
  end

`ifdef DDR_WR_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  // Underrun: the DDR side is ready but the FIFO has nothing to give.
  always_comb begin
    stall_d = stall_q;
    if (start_acc) begin
      stall_d = '0;
    end else if ((state_q == ST_DATA) && wready && !fifo_vld && (stall_q != '1)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_ddr_wr_burst_master.sv
// Bench for ddr_wr_burst_master: table frames, hand-written corner sequences and
// randomized frames checked against a burst-splitting reference model.
`timescale 1ns/1ps
module tb_ddr_wr_burst_master;
  import ddr_wr_pkg::*;

  localparam int DW = 256;
  localparam int AW = 28;
  localparam int BL = 16;
  localparam int BW = 24;

  logic          rd_clk = 1'b0;
  logic          rd_rst;
  logic          frame_start;
  logic [AW-1:0] frame_base;
  logic [BW-1:0] frame_beats;
  logic [DW-1:0] fifo_data;
  logic          fifo_vld;
  logic          fifo_rd_en;
  logic [AW-1:0] awaddr;
  logic [7:0]    awlen;
  logic          awvalid;
  logic          awready;
  logic [DW-1:0] wdata;
  logic          wlast;
  logic          wvalid;
  logic          wready;
  logic          bvalid;
  logic [1:0]    bresp;
  logic          bready;
  logic          busy;
  logic          frame_done;
  logic          wr_err;
`ifdef DDR_WR_STALL_CNT_EN
  logic [31:0]   stall_cnt;
`endif

  always #5 rd_clk = ~rd_clk;

  ddr_wr_burst_master #(
    .DATA_W(DW), .ADDR_W(AW), .BURST_LEN(BL), .BEATS_W(BW)
  ) dut (
    .rd_clk(rd_clk), .rd_rst(rd_rst),
    .frame_start(frame_start), .frame_base(frame_base), .frame_beats(frame_beats),
    .fifo_data(fifo_data), .fifo_vld(fifo_vld), .fifo_rd_en(fifo_rd_en),
    .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bresp(bresp), .bready(bready),
    .busy(busy), .frame_done(frame_done), .wr_err(wr_err)
`ifdef DDR_WR_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    len;
  } aw_t;

  typedef struct {
    logic [AW-1:0] base;
    int            beats;
    int            err_burst;
    int            exp_bursts;
    logic [AW-1:0] exp_last_addr;
    logic [7:0]    exp_last_len;
    logic          exp_err;
  } vec_t;

  int  n_cmp, n_bad, cyc, tag;
  int  beat_idx, pop_idx, cur_beats, err_burst;
  int  b_owed, b_num, last_b_cyc, done_cnt, done_cyc, aw_stall_cycles;
  int  vld_pct, aw_pct, w_pct, b_pct, gap_after, gap_left, aw_hold;
  bit  w_toggle, spur_en, started, fs_req;
  bit  pop_now, wbeat_now, b_now, prev_stall;
  logic          err_at_done, last_busy, last_err;
  logic [AW-1:0] fs_base, prev_addr;
  logic [BW-1:0] fs_beats;
  logic [7:0]    prev_len;
  aw_t           aw_got[$];

  function automatic void chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endfunction

  function automatic bit roll(input int pct);
    return int'($urandom_range(99)) < pct;
  endfunction

  function automatic logic [DW-1:0] wgen(input int t, input int i);
    logic [DW-1:0] w;
    for (int l = 0; l < DW / 32; l++)
      w[l*32 +: 32] = (32'(t) * 32'h01000193) ^ (32'(i) * 32'h9E3779B1) ^ 32'(l);
    return w;
  endfunction

  task automatic drive();
    if (fs_req) begin
      frame_start = 1'b1;
      frame_base  = fs_base;
      frame_beats = fs_beats;
      fs_req      = 1'b0;
    end else begin
      frame_start = spur_en && started && (done_cnt == 0) && roll(15);
      frame_base  = AW'($urandom);
      frame_beats = BW'($urandom_range(1, 300));
    end
    if (gap_left > 0 && beat_idx >= gap_after) begin
      fifo_vld = 1'b0;
      gap_left--;
    end else begin
      fifo_vld = roll(vld_pct);
    end
    fifo_data = wgen(tag, pop_idx);
    if (aw_hold > 0) begin
      awready = 1'b0;
      if (started) aw_hold--;
    end else begin
      awready = roll(aw_pct);
    end
    wready = w_toggle ? ~wready : roll(w_pct);
    bvalid = (b_owed > 0) && roll(b_pct);
    bresp  = (bvalid && b_num == err_burst) ? 2'd2 : 2'd0;
  endtask

  task automatic observe();
    pop_now   = fifo_rd_en && fifo_vld;
    wbeat_now = wvalid && wready;
    b_now     = bvalid && bready;
    last_busy = busy;
    last_err  = wr_err;
    chk("rd_en_outside_data", fifo_rd_en && (awvalid || bready), 0);
    chk("wvalid_without_fifo_vld", wvalid && !fifo_vld, 0);
    chk("wlast_without_wvalid", wlast && !wvalid, 0);
    if (wvalid) chk("rd_en_follows_wready", fifo_rd_en, wready);
    if (prev_stall) begin
      chk("awvalid_held", awvalid, 1);
      chk("awaddr_stable", awaddr, prev_addr);
      chk("awlen_stable", awlen, prev_len);
    end
    prev_stall = awvalid && !awready;
    prev_addr  = awaddr;
    prev_len   = awlen;
    if (awvalid && !awready) aw_stall_cycles++;
    if (awvalid && awready) aw_got.push_back('{awaddr, awlen});
    if (wbeat_now) begin
      chk("wdata_order", wdata, wgen(tag, beat_idx));
      chk("wlast_position", wlast, (beat_idx % BL == BL - 1) || (beat_idx == cur_beats - 1));
    end
    if (b_now) last_b_cyc = cyc;
    if (frame_done) begin
      done_cnt++;
      done_cyc    = cyc;
      err_at_done = wr_err;
      chk("busy_low_at_done", busy, 0);
    end
  endtask

  task automatic commit();
    if (pop_now) pop_idx++;
    if (wbeat_now) begin
      beat_idx++;
      if (beat_idx % BL == 0 || beat_idx == cur_beats) b_owed++;
    end
    if (b_now) begin
      b_owed--;
      b_num++;
    end
  endtask

  task automatic step();
    drive();
    @(negedge rd_clk);
    observe();
    @(posedge rd_clk);
    #1;
    commit();
    cyc++;
  endtask

  task automatic prep(input logic [AW-1:0] base, input int beats, input int err);
    tag++;
    beat_idx = 0; pop_idx = 0; cur_beats = beats; err_burst = err;
    b_owed = 0; b_num = 0; last_b_cyc = -1; done_cnt = 0; done_cyc = -1;
    aw_got.delete(); aw_stall_cycles = 0; prev_stall = 0; started = 0;
    fs_req = 1; fs_base = base; fs_beats = BW'(beats);
  endtask

  task automatic run_frame(input logic [AW-1:0] base, input int beats, input int err);
    int start_cyc, nb, guard, len;
    prep(base, beats, err);
    start_cyc = cyc;
    step();
    started = 1;
    step();
    if (beats > 0) chk("busy_after_start", last_busy, 1);
    chk("wr_err_cleared_on_start", last_err, 0);
    guard = 0;
    while (done_cnt == 0 && guard < 4000) begin
      step();
      guard++;
    end
    if (done_cnt == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL frame_done_timeout: got no frame_done in %0d cycles, required one", guard);
    end
    started = 0;
    step();
    step();
    nb = (beats + BL - 1) / BL;
    chk("frame_done_count", done_cnt, 1);
    chk("aw_count", aw_got.size(), nb);
    for (int k = 0; k < nb && k < aw_got.size(); k++) begin
      len = (beats - k * BL > BL) ? BL : beats - k * BL;
      chk($sformatf("awaddr_b%0d", k), aw_got[k].addr, AW'(base + k * BL * BYTES_PER_BEAT));
      chk($sformatf("awlen_b%0d", k), aw_got[k].len, len - 1);
    end
    chk("beats_transferred", beat_idx, beats);
    chk("fifo_pops", pop_idx, beats);
    chk("wr_err_at_done", err_at_done, (err >= 0) && (err < nb));
    if (beats > 0) chk("done_after_last_b", done_cyc, last_b_cyc + 1);
    else chk("zero_frame_done_latency", (done_cyc > start_cyc) && (done_cyc - start_cyc <= 2), 1);
    chk("busy_idle_after_frame", busy, 0);
  endtask

  task automatic check_reset_outputs();
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_wlast", wlast, 0);
    chk("rst_bready", bready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_wr_err", wr_err, 0);
    chk("rst_fifo_rd_en", fifo_rd_en, 0);
    chk("rst_awaddr", awaddr, 0);
    chk("rst_awlen", awlen, 0);
`ifdef DDR_WR_STALL_CNT_EN
    chk("rst_stall_cnt", stall_cnt, 0);
`endif
  endtask

  task automatic ideal_knobs();
    vld_pct = 100; aw_pct = 100; w_pct = 100; b_pct = 100;
    w_toggle = 0; spur_en = 0; gap_left = 0; gap_after = 0; aw_hold = 0;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation still running at 5 ms, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[7];
    int   guard, beats, err;
    logic [AW-1:0] base;

    n_cmp = 0; n_bad = 0; cyc = 0; tag = 0;
    b_owed = 0; b_num = 0; done_cnt = 0; beat_idx = 0; pop_idx = 0; cur_beats = 0;
    err_burst = -1; prev_stall = 0; started = 0; fs_req = 0;
    ideal_knobs();
    rd_rst = 1'b1; frame_start = 1'b0; frame_base = '0; frame_beats = '0;
    fifo_vld = 1'b0; fifo_data = '0; awready = 1'b0; wready = 1'b0;
    bvalid = 1'b0; bresp = 2'd0;

    repeat (3) @(posedge rd_clk);
    #1;
    check_reset_outputs();
    rd_rst = 1'b0;
    @(posedge rd_clk);
    #1;

    tbl[0] = '{28'h0100000, 32, -1, 2, 28'h0100200, 8'd15, 1'b0};
    tbl[1] = '{28'h0100000, 37, -1, 3, 28'h0100400, 8'd4,  1'b0};
    tbl[2] = '{28'h0200000, 1,  -1, 1, 28'h0200000, 8'd0,  1'b0};
    tbl[3] = '{28'hFFFFE00, 48, -1, 3, 28'h0000200, 8'd15, 1'b0};
    tbl[4] = '{28'h0400000, 20,  1, 2, 28'h0400200, 8'd3,  1'b1};
    tbl[5] = '{28'h0000000, 0,  -1, 0, 28'h0000000, 8'd0,  1'b0};
    tbl[6] = '{28'h0A00000, 16,  0, 1, 28'h0A00000, 8'd15, 1'b1};

    for (int i = 0; i < 7; i++) begin
      run_frame(tbl[i].base, tbl[i].beats, tbl[i].err_burst);
      chk($sformatf("tbl%0d_bursts", i), aw_got.size(), tbl[i].exp_bursts);
      if (tbl[i].exp_bursts > 0 && aw_got.size() > 0) begin
        chk($sformatf("tbl%0d_last_awaddr", i), aw_got[$].addr, tbl[i].exp_last_addr);
        chk($sformatf("tbl%0d_last_awlen", i), aw_got[$].len, tbl[i].exp_last_len);
      end
      chk($sformatf("tbl%0d_wr_err", i), err_at_done, tbl[i].exp_err);
    end
    chk("wr_err_sticky_in_idle", wr_err, 1);

    // FIFO underrun of five cycles in the middle of the first burst.
    gap_after = 4; gap_left = 5;
    run_frame(28'h0500000, 16, -1);
`ifdef DDR_WR_STALL_CNT_EN
    chk("stall_cnt_underrun", stall_cnt, 5);
`endif
    ideal_knobs();

    aw_hold = 10;
    run_frame(28'h0600000, 20, -1);
    chk("aw_stall_cycles", aw_stall_cycles, 10);
    ideal_knobs();

    w_toggle = 1;
    run_frame(28'h0700000, 24, -1);
    ideal_knobs();

    // Asynchronous reset after seven beats of the first burst.
    prep(28'h0800000, 32, -1);
    step();
    started = 1;
    guard = 0;
    while (beat_idx < 7 && guard < 200) begin
      step();
      guard++;
    end
    if (beat_idx < 7) begin
      n_cmp++; n_bad++;
      $display("FAIL reset_setup_timeout: got %0d beats, required 7", beat_idx);
    end
    rd_rst = 1'b1;
    #1;
    check_reset_outputs();
    started = 0;
    @(negedge rd_clk);
    rd_rst = 1'b0;
    b_owed = 0;
    @(posedge rd_clk);
    #1;
    run_frame(28'h0900000, 18, -1);

    for (int r = 0; r < 12; r++) begin
      vld_pct = $urandom_range(40, 100);
      aw_pct  = $urandom_range(30, 100);
      w_pct   = $urandom_range(30, 100);
      b_pct   = $urandom_range(30, 100);
      spur_en = 1;
      beats   = $urandom_range(0, 70);
      base    = AW'($urandom_range(0, (1 << 19) - 1)) << 9;
      err     = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : -1;
      run_frame(base, beats, err);
    end
    ideal_knobs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
